// File: rtl/instr_encoder.sv
// Program loader: packs an RV32I subset mnemonic plus operands into a 32-bit word and writes it
// to instruction memory at an auto-incrementing word address.
module instr_encoder #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [12:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err,
  output logic              full,
  output logic [ADDR_W-1:0] count
);

  typedef enum logic [1:0] {StIdle, StEnc, StWr, StFull} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [6:0]        OpcR     = 7'b0110011;

  state_e            state_q;
  logic [3:0]        op_q;
  logic [4:0]        rd_q, rs1_q, rs2_q;
  logic [12:0]       imm_q;
  logic [ADDR_W-1:0] count_q;
  logic              full_q, err_q;
  logic [31:0]       wdata_q;

  logic [31:0]       enc;
  logic              illegal;

  // 12-bit immediates must sign-extend cleanly from the 13-bit input, so imm[12] == imm[11].
  always_comb begin
    enc     = 32'h0;
    illegal = 1'b0;
    case (op_q)
      4'd0: enc = {7'b0000000, rs2_q, rs1_q, 3'b000, rd_q, OpcR};
      4'd1: enc = {7'b0100000, rs2_q, rs1_q, 3'b000, rd_q, OpcR};
      4'd2: enc = {7'b0000000, rs2_q, rs1_q, 3'b111, rd_q, OpcR};
      4'd3: enc = {7'b0000000, rs2_q, rs1_q, 3'b110, rd_q, OpcR};
      4'd4: enc = {7'b0000000, rs2_q, rs1_q, 3'b100, rd_q, OpcR};
      4'd5: enc = {7'b0000000, rs2_q, rs1_q, 3'b010, rd_q, OpcR};
      4'd6: begin
        illegal = imm_q[12] != imm_q[11];
        enc     = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b0010011};
      end
      4'd7: begin
        illegal = imm_q[12] != imm_q[11];
        enc     = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b0000011};
      end
      4'd8: begin
        illegal = imm_q[12] != imm_q[11];
        enc     = {imm_q[11:5], rs2_q, rs1_q, 3'b000, imm_q[4:0], 7'b0100011};
      end
      4'd9: begin
        illegal = imm_q[0];
        enc     = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000, imm_q[4:1], imm_q[11],
                   7'b1100011};
      end
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 4'h0;
      rd_q    <= 5'h0;
      rs1_q   <= 5'h0;
      rs2_q   <= 5'h0;
      imm_q   <= 13'h0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 32'h0;
    end else begin
      err_q <= 1'b0;
      if (clear) begin
        state_q <= StIdle;
        count_q <= '0;
        full_q  <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (in_valid) begin
              op_q    <= op_sel;
              rd_q    <= rd;
              rs1_q   <= rs1;
              rs2_q   <= rs2;
              imm_q   <= imm;
              state_q <= StEnc;
            end
          end
          StEnc: begin
            if (illegal) begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end else begin
              wdata_q <= enc;
              state_q <= StWr;
            end
          end
          StWr: begin
            count_q <= count_q + 1'b1;
            if (count_q == LastAddr) begin
              full_q  <= 1'b1;
              state_q <= StFull;
            end else begin
              state_q <= StIdle;
            end
          end
          StFull:  state_q <= StFull;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // clear aborts a pending write in the same cycle it is raised.
  assign in_ready  = (state_q == StIdle) && !clear;
  assign mem_we    = (state_q == StWr) && !clear;
  assign mem_addr  = count_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;
  assign full      = full_q;
  assign count     = count_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the control-unit decode path: packs a mnemonic code plus register/immediate operands into a 32-bit RV32I instruction word.
- Supports the same ten-instruction subset: ADD, SUB, AND, OR, XOR, SLT, ADDI, LB, SB, BEQ.
- Writes each encoded word into instruction memory at an auto-incrementing word address.
- Used as the program loader feeding the processor's instruction ROM/RAM from a testbench or host interface.

Parameters:
- ADDR_W, 6, width of mem_addr / count.
- DEPTH, 64, number of writable words; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous restart of the write pointer; lower priority than rst.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  encoder can accept a bundle.
- op_sel  input  4  instruction code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 ADDI, 7 LB, 8 SB, 9 BEQ; 10-15 illegal.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- imm  input  13  signed immediate; byte offset for BEQ.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_W  word address of the write.
- mem_wdata  output  32  encoded instruction.
- err  output  1  one-cycle pulse: bundle rejected.
- full  output  1  DEPTH words written.
- count  output  ADDR_W  words written since reset/clear.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - count, mem_addr, mem_wdata, mem_we, err and full all go to 0.
  - in_ready is 1 from the first cycle after reset.
- FSM states: IDLE, ENC, WR, FULL.
- IDLE:
  - in_ready = !clear.
  - On in_valid && in_ready, latch the operands and go to ENC.
- ENC:
  - Check the latched bundle. It is illegal if any of the following holds:
    - op_sel > 9;
    - op_sel 6/7/8 with imm[12] != imm[11] (immediate out of range -2048..2047);
    - op_sel 9 with imm[0] = 1 (misaligned branch).
  - Illegal bundle: pulse err for the next cycle, no write, count unchanged, return to IDLE.
  - Legal bundle: register the encoded word into mem_wdata, go to WR.
- Encodings (bit fields high to low):
  - R-type: funct7 | rs2 | rs1 | funct3 | rd | 0110011.
    - funct3: ADD 000, SUB 000, AND 111, OR 110, XOR 100, SLT 010.
    - funct7: 0100000 for SUB, 0000000 for the rest.
  - ADDI: imm[11:0] | rs1 | 000 | rd | 0010011.
  - LB: imm[11:0] | rs1 | 000 | rd | 0000011.
  - SB: imm[11:5] | rs2 | rs1 | 000 | imm[4:0] | 0100011.
  - BEQ: imm[12] | imm[10:5] | rs2 | rs1 | 000 | imm[4:1] | imm[11] | 1100011.
  - Fields unused by an instruction type are ignored; rd = 0 is legal.
- WR:
  - mem_we = 1 for exactly one cycle, with mem_addr = count.
  - At the next edge count increments.
  - If the new count == DEPTH (or count was DEPTH-1), set full and go to FULL; otherwise go to IDLE.
  - In ADDR_W-wide arithmetic, count reads 0 once DEPTH = 2**ADDR_W words are written; the full flag disambiguates this case.
- Latency and throughput:
  - Bundle accepted at edge k; mem_we is high between edges k+1 and k+2.
  - in_ready is high again after edge k+2.
  - Throughput is one instruction per 3 cycles.
- FULL:
  - in_ready = 0; in_valid is ignored; no writes.
  - Exit only via rst or clear.
- clear:
  - From any state: at the edge, count=0, full=0, state=IDLE.
  - If clear is asserted in ENC or WR, the operation is aborted: mem_we is forced 0 that cycle, no err, the word is discarded.
  - clear and in_valid together in IDLE: no accept.
- mem_wdata holds its last value when mem_we = 0.

Test Plan:
- ADD rd=3, rs1=1, rs2=2 after reset -> mem_we one cycle, addr 0, wdata 0x002081B3; count=1.
- Back-to-back SUB rd=5, rs1=6, rs2=7, then LB rd=4, rs1=1, imm=0:
  - -> 0x407302B3 at addr 0, 0x00008203 at addr 1;
  - -> in_ready low for exactly 2 cycles after each accept.
- ADDI rd=1, rs1=0, imm=-1 -> 0xFFF00093.
- SB rs1=1, rs2=2, imm=8 -> 0x00208423.
- BEQ rs1=1, rs2=2, imm=-4 -> 0xFE208EE3.
- Error cases, each -> err pulse, no mem_we, count unchanged:
  - BEQ with imm=3;
  - op_sel=12;
  - ADDI with imm=13'h0800.
- ADDR_W=2, DEPTH=4:
  - write 4 words -> full=1, in_ready=0, count=0, a fifth in_valid is ignored;
  - then clear -> full=0, next write lands at addr 0.
- Assert clear during WR -> mem_we stays 0 that cycle and count=0.
